// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - count sample classifier with timestamped event FIFO (optional macro COUNT_MON_STEP_LOG_EN)
module count_event_monitor #(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          count,
    input  logic                sample_en,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [2:0]          ev_type,
    output logic [3:0]          ev_prev,
    output logic [3:0]          ev_curr,
    output logic [TS_WIDTH-1:0] ev_time,
    output logic [4:0]          fifo_level,
    output logic                overflow,
    output logic [7:0]          drop_count
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W = 11 + TS_WIDTH;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    localparam logic [2:0] T_NONE    = 3'd0;
    localparam logic [2:0] T_WRAP_UP = 3'd1;
    localparam logic [2:0] T_WRAP_DN = 3'd2;
    localparam logic [2:0] T_JUMP    = 3'd3;
    localparam logic [2:0] T_RANGE   = 3'd4;
    localparam logic [2:0] T_STEP_UP = 3'd5;
    localparam logic [2:0] T_STEP_DN = 3'd6;

`ifdef COUNT_MON_STEP_LOG_EN
    localparam logic STEP_LOG = 1'b1;
`else
    localparam logic STEP_LOG = 1'b0;
`endif

    typedef enum logic {
        ST_EMPTY,
        ST_TRACK
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [REC_W-1:0]    mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [4:0]          level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic [2:0]          ev_code;
    logic                in_range;
    logic [4:0]          curr_ext, prev_inc, prev_dec;
    logic                push_req;
    logic                head_valid, pop, full, wr_en, drop;
    logic [REC_W-1:0]    rec, head;

    // Classify the incoming sample against the previously held sample
    always_comb begin
        ev_code  = T_NONE;
        in_range = (count >= 4'd2) && (count <= 4'd10);
        curr_ext = {1'b0, count};
        prev_inc = {1'b0, prev_q} + 5'd1;
        prev_dec = {1'b0, prev_q} - 5'd1;
        if (!in_range) begin
            ev_code = T_RANGE;
        end else if (state_q == ST_TRACK) begin
            if (count == prev_q)
                ev_code = T_NONE;
            else if (prev_q == 4'd10 && count == 4'd2)
                ev_code = T_WRAP_UP;
            else if (prev_q == 4'd2 && count == 4'd10)
                ev_code = T_WRAP_DN;
            else if (curr_ext == prev_inc)
                ev_code = T_STEP_UP;
            else if (curr_ext == prev_dec)
                ev_code = T_STEP_DN;
            else
                ev_code = T_JUMP;
        end
        push_req = sample_en && (ev_code != T_NONE) &&
                   (STEP_LOG || ((ev_code != T_STEP_UP) && (ev_code != T_STEP_DN)));
        rec = {ev_code, prev_q, count, ts_q};
    end

    // Next-state for the tracking FSM, held sample and timestamp
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        ts_d    = ts_q + TS_WIDTH'(1);
        if (sample_en) begin
            state_d = ST_TRACK;
            prev_d  = count;
        end
    end

    // Event FIFO: no fall-through when empty, push+pop accepted when full
    always_comb begin
        head_valid = (level_q != 5'd0);
        pop        = head_valid && ev_ready;
        full       = (level_q == DEPTH_L);
        wr_en      = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = rec;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            prev_q     <= 4'd0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Event storage; contents are masked by the level so need no reset
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Head outputs forced to zero whenever the FIFO is empty
    always_comb begin
        head       = mem_q[rd_ptr_q];
        ev_valid   = head_valid;
        ev_type    = head_valid ? head[REC_W-1 -: 3]      : 3'd0;
        ev_prev    = head_valid ? head[REC_W-4 -: 4]      : 4'd0;
        ev_curr    = head_valid ? head[REC_W-8 -: 4]      : 4'd0;
        ev_time    = head_valid ? head[TS_WIDTH-1:0]      : '0;
        fifo_level = level_q;
        overflow   = overflow_q;
        drop_count = drop_cnt_q;
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - randomized and directed checks of count_event_monitor against a queue model
module tb_count_event_monitor;

    localparam int DEPTH = 4;
    localparam int TSW   = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     count = 4'd0;
    logic           sample_en = 1'b0;
    logic           ev_ready = 1'b0;
    logic           ev_valid;
    logic [2:0]     ev_type;
    logic [3:0]     ev_prev, ev_curr;
    logic [TSW-1:0] ev_time;
    logic [4:0]     fifo_level;
    logic           overflow;
    logic [7:0]     drop_count;

    count_event_monitor #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clock(clock), .reset(reset), .count(count), .sample_en(sample_en),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
        .ev_prev(ev_prev), .ev_curr(ev_curr), .ev_time(ev_time),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

`ifdef COUNT_MON_STEP_LOG_EN
    localparam bit LOG_STEPS = 1'b1;
`else
    localparam bit LOG_STEPS = 1'b0;
`endif

    typedef struct {
        int typ;
        int prev;
        int curr;
        int ts;
    } rec_t;

    rec_t mq[$];
    int   m_prev = 0;
    bit   m_track = 1'b0;
    int   m_ts = 0;
    bit   m_ovf = 1'b0;
    int   m_drops = 0;
    bit   chk_on = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Spec rule list: returns the event type, 0 when no event results
    function automatic int classify(input int p, input int c, input bit track);
        if (c < 2 || c > 10) return 4;
        if (!track) return 0;
        if (c == p) return 0;
        if (p == 10 && c == 2) return 1;
        if (p == 2 && c == 10) return 2;
        if (c == p + 1) return 5;
        if (c == p - 1) return 6;
        return 3;
    endfunction

    // Reference model: an unbounded queue clipped to DEPTH entries
    always @(posedge clock) begin
        int   code;
        bit   pop;
        rec_t r;
        if (reset) begin
            mq.delete();
            m_prev = 0; m_track = 0; m_ts = 0; m_ovf = 0; m_drops = 0;
        end else begin
            pop  = (mq.size() > 0) && ev_ready;
            code = sample_en ? classify(m_prev, int'(count), m_track) : 0;
            if (code >= 5 && !LOG_STEPS) code = 0;
            if (pop) void'(mq.pop_front());
            if (code != 0) begin
                if (mq.size() < DEPTH) begin
                    r.typ = code; r.prev = m_prev; r.curr = int'(count); r.ts = m_ts;
                    mq.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_ts = (m_ts + 1) % (1 << TSW);
            if (sample_en) begin
                m_prev  = int'(count);
                m_track = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (chk_on) begin
            chk("ev_valid", int'(ev_valid), int'(mq.size() > 0));
            chk("fifo_level", int'(fifo_level), mq.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("drop_count", int'(drop_count), m_drops);
            if (mq.size() > 0) begin
                chk("ev_type", int'(ev_type), mq[0].typ);
                chk("ev_prev", int'(ev_prev), mq[0].prev);
                chk("ev_curr", int'(ev_curr), mq[0].curr);
                chk("ev_time", int'(ev_time), mq[0].ts);
            end else begin
                chk("ev_idle_zero", int'({ev_type, ev_prev, ev_curr, ev_time}), 0);
            end
        end
    end

    task automatic drive(input bit en, input int cnt, input bit rdy);
        @(negedge clock);
        sample_en = en;
        count     = 4'(cnt);
        ev_ready  = rdy;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; sample_en = 1'b0; ev_ready = 1'b0; count = 4'd0;
        @(negedge clock);
        chk("reset_all_zero",
            int'({ev_valid, ev_type, ev_prev, ev_curr, ev_time, fifo_level, overflow, drop_count}), 0);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_on = 1'b1;
        do_reset();

        // Consecutive steps after the first sample
        drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 0); drive(0, 0, 0);
        if (LOG_STEPS) begin
            chk("steps_level", int'(fifo_level), 2);
            chk("steps_type", int'(ev_type), 5);
        end else begin
            chk("steps_level", int'(fifo_level), 0);
            chk("steps_valid", int'(ev_valid), 0);
        end
        drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 0);

        // Wrap up with a ready consumer
        do_reset();
        drive(1, 10, 1); drive(1, 2, 1); drive(0, 0, 1);
        chk("wrapup_valid", int'(ev_valid), 1);
        chk("wrapup_type", int'(ev_type), 1);
        chk("wrapup_prev", int'(ev_prev), 10);
        chk("wrapup_curr", int'(ev_curr), 2);
        chk("wrapup_time", int'(ev_time), 2);
        drive(0, 0, 1);
        chk("wrapup_one_cycle", int'(ev_valid), 0);

        // Wrap down followed by a jump
        do_reset();
        drive(1, 2, 0); drive(1, 10, 0); drive(1, 10, 0); drive(1, 6, 0); drive(0, 0, 0);
        chk("wrapdn_level", int'(fifo_level), 2);
        chk("wrapdn_type", int'(ev_type), 2);
        chk("wrapdn_prev", int'(ev_prev), 2);
        chk("wrapdn_curr", int'(ev_curr), 10);
        drive(0, 0, 1); drive(0, 0, 0);
        chk("jump_type", int'(ev_type), 3);
        chk("jump_prev", int'(ev_prev), 10);
        chk("jump_curr", int'(ev_curr), 6);
        drive(0, 0, 1); drive(0, 0, 0);

        // Out-of-range sample then back in range
        do_reset();
        drive(1, 5, 1); drive(1, 12, 1); drive(1, 2, 0);
        chk("range_type", int'(ev_type), 4);
        chk("range_curr", int'(ev_curr), 12);
        drive(0, 0, 1); drive(0, 0, 0);
        chk("after_range_type", int'(ev_type), 3);
        chk("after_range_prev", int'(ev_prev), 12);

        // Five wraps into a four-deep FIFO with no consumer
        do_reset();
        drive(1, 10, 0);
        for (int i = 0; i < 5; i++) drive(1, (i % 2 == 0) ? 2 : 10, 0);
        drive(0, 0, 0);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drops", int'(drop_count), 1);
        chk("ovf_head_type", int'(ev_type), 1);
        chk("ovf_head_prev", int'(ev_prev), 10);

        // Full FIFO with simultaneous push and pop, then reset
        do_reset();
        drive(1, 10, 0);
        for (int i = 0; i < 4; i++) drive(1, (i % 2 == 0) ? 2 : 10, 0);
        drive(1, 2, 1); drive(0, 0, 0);
        chk("pushpop_level", int'(fifo_level), 4);
        chk("pushpop_ovf", int'(overflow), 0);
        do_reset();

        // Drop counter saturation
        drive(1, 10, 0);
        for (int i = 0; i < 300; i++) drive(1, (i % 2 == 0) ? 2 : 10, 0);
        drive(0, 0, 0);
        chk("drop_saturate", int'(drop_count), 255);
        do_reset();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            reset     = ($urandom_range(0, 299) == 0);
            sample_en = ($urandom_range(0, 99) < 60);
            count     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(2, 10));
            ev_ready  = ($urandom_range(0, 99) < 40);
        end
        @(negedge clock);
        reset = 1'b0; sample_en = 1'b0; ev_ready = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_WIDTH, default 8, free-running timestamp width.
REQ-003 SHALL have port clock  input  1  the only clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port count  input  4  counter output, range 2..10.
REQ-006 SHALL have port sample_en  input  1  count is sampled on cycles where high.
REQ-007 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts head when ev_valid and ev_ready are both high.
REQ-009 SHALL have port ev_type  output  3  head event type.
REQ-010 SHALL have port ev_prev / ev_curr  output  4 each  previous and current sample of the head event.
REQ-011 SHALL have port ev_time  output  TS_WIDTH  timestamp of the head event.
REQ-012 SHALL have port fifo_level  output  5  number of queued events.
REQ-013 SHALL have port overflow  output  1  sticky flag, set on a dropped event.
REQ-014 SHALL have port drop_count  output  8  saturating count of dropped events.

Function
REQ-015 SHALL implement FSM EMPTY (no prior sample) and TRACK (prior sample held in prev_q).
- EMPTY -> TRACK on the first sample_en.
- TRACK -> TRACK otherwise.
REQ-016 SHALL, in EMPTY, capture the sample into prev_q and generate no event, unless the sample is out of range.
REQ-017 SHALL, in TRACK, classify curr=count against prev_q with priority:
- RANGE_ERR=4 when curr<2 or curr>10;
- HOLD when curr==prev_q (no event);
- WRAP_UP=1 when prev_q==10 and curr==2;
- WRAP_DN=2 when prev_q==2 and curr==10;
- STEP_UP when curr==prev_q+1;
- STEP_DN when curr==prev_q-1;
- JUMP=3 in all other cases.
REQ-018 SHALL update prev_q with every sampled value, including out-of-range values.
REQ-019 SHALL push an event record {type, prev_q, curr, timestamp} one cycle after the sampling edge, so that ev_valid is high in the cycle after the sample when the FIFO was empty.
REQ-020 SHALL free-run the timestamp counter by one every cycle, wrapping from all-ones to 0; the record captures its value on the sampling edge.
REQ-021 SHALL keep ev_* stable while ev_valid is high and ev_ready is low.
REQ-022 SHALL, when the FIFO is full and a push occurs with no pop in the same cycle, drop the new event, set overflow, and increment drop_count, which saturates at 255.
REQ-023 SHALL, when the FIFO is full and a push and a pop occur in the same cycle, accept both, leaving fifo_level unchanged and setting no overflow.
REQ-024 SHALL, when the FIFO is empty, not combine a push with a same-cycle pop (no fall-through); the pushed entry appears in the following cycle.
REQ-025 SHALL ignore ev_ready while ev_valid is low.

Reset
REQ-026 SHALL, on reset high at a clock edge, do all of the following:
- return the FSM to EMPTY;
- flush the FIFO;
- clear the timestamp, overflow and drop_count;
- drive ev_valid=0, ev_type=0, ev_prev=0, ev_curr=0, ev_time=0 and fifo_level=0.
REQ-027 SHALL, when reset is asserted mid-operation, discard queued events and any in-flight push, with no event produced in the reset cycle.

Configuration
REQ-028 SHALL use macro COUNT_MON_STEP_LOG_EN.
- Defined: STEP_UP=5 and STEP_DN=6 events are pushed like any other event.
- Undefined: steps are classified but not pushed, and type codes 5 and 6 never appear.

Verification
REQ-029 SHALL cover scenario: reset, then samples 2,3,4 -> no events, fifo_level=0 (macro undefined); with macro defined -> two events of type 5.
REQ-030 SHALL cover scenario: samples 10 then 2 with ev_ready=1 -> one event type=1, prev=10, curr=2, ev_valid high for one cycle.
REQ-031 SHALL cover scenario: samples 2 then 10, then 10 then 6 -> events type=2 (prev 2, curr 10), then type=3 (prev 10, curr 6).
REQ-032 SHALL cover scenario: sample 12 in TRACK -> type=4, curr=12; a following sample of 2 -> type=3, prev=12.
REQ-033 SHALL cover scenario: ev_ready=0, then 5 wrap events with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, drop_count=1, and the head still holds the first event.
REQ-034 SHALL cover scenario: full FIFO, with a push and ev_ready=1 in the same cycle -> fifo_level stays 4 and overflow stays 0; reset asserted afterwards -> all outputs 0 on the next cycle.
